// File: rtl/mem_arb_pkg.sv
// Shared widths, requester IDs and command types for the system RAM arbiter.
// The RAM is 64K x 8 with one-cycle synchronous read latency.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int WAIT_W = 8;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_cmd_t;

    // A requester owns the next read-return slot only when it won a read access
    function automatic logic [1:0] nextReadOwner(input logic gnt0, input logic we0,
                                                 input logic gnt1, input logic we1);
        logic [1:0] owner;
        owner[REQ_CPU] = gnt0 & ~we0;
        owner[REQ_DMA] = gnt1 & ~we1;
        return owner;
    endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// Grant selection for the two RAM requesters: CPU has fixed priority, and a
// wait counter hands the DMA port the next contested cycle once it has waited MAX_WAIT cycles.
module mem_arb_fairness
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
)
(
    input  logic CLK,
    input  logic RESET,
    input  logic REQ0,
    input  logic REQ1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [WAIT_W-1:0] MAX_CNT  = WAIT_W'(MAX_WAIT);
    localparam bit                GUARD_ON = (MAX_WAIT != 0);

    logic [WAIT_W-1:0] r_waitCnt;
    logic              w_dmaTurn;

    always_comb begin
        w_dmaTurn = GUARD_ON && (r_waitCnt == MAX_CNT);
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        // No access is accepted while reset is held, so a read in flight is dropped
        if (!RESET) begin
            if (REQ0 && REQ1) begin
                gnt1 = w_dmaTurn;
                gnt0 = !w_dmaTurn;
            end else begin
                gnt0 = REQ0;
                gnt1 = REQ1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_waitCnt <= '0;
        end else if (!REQ1 || gnt1) begin
            r_waitCnt <= '0;
        end else if (r_waitCnt != MAX_CNT) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port system RAM between the 6502 core (port 0) and the DMA/loader (port 1).
// One access per cycle; read data returns to the winning port one cycle after its ACK.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
)
(
    input  logic              CLK,
    input  logic              RESET,

    input  logic              REQ0,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [DATA_W-1:0] WDATA0,
    output logic              ACK0,
    output logic              RVALID0,
    output logic [DATA_W-1:0] RDATA0,

    input  logic              REQ1,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              ACK1,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA1,

    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DIN,
    input  logic [DATA_W-1:0] MEM_DOUT
);

    logic     w_gnt0;
    logic     w_gnt1;
    mem_cmd_t w_cmd0;
    mem_cmd_t w_cmd1;
    mem_cmd_t w_memCmd;
    logic [1:0] r_rdOwner;

    mem_arb_fairness #(
        .MAX_WAIT (MAX_WAIT)
    ) u_fairness (
        .CLK   (CLK),
        .RESET (RESET),
        .REQ0  (REQ0),
        .REQ1  (REQ1),
        .gnt0  (w_gnt0),
        .gnt1  (w_gnt1)
    );

    assign w_cmd0 = '{we: WE0, addr: ADDR0, data: WDATA0};
    assign w_cmd1 = '{we: WE1, addr: ADDR1, data: WDATA1};

    // Idle cycles drive an all-zero command so the RAM never sees a stray write
    always_comb begin
        w_memCmd = '0;
        if (w_gnt0) begin
            w_memCmd = w_cmd0;
        end else if (w_gnt1) begin
            w_memCmd = w_cmd1;
        end
    end

    assign MEM_WE   = w_memCmd.we;
    assign MEM_ADDR = w_memCmd.addr;
    assign MEM_DIN  = w_memCmd.data;
    assign ACK0     = w_gnt0;
    assign ACK1     = w_gnt1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rdOwner <= '0;
        end else begin
            r_rdOwner <= nextReadOwner(w_gnt0, WE0, w_gnt1, WE1);
        end
    end

    // RAM output lines up with the owner register, so only the owner sees data
    assign RVALID0 = r_rdOwner[REQ_CPU];
    assign RVALID1 = r_rdOwner[REQ_DMA];
    assign RDATA0  = RVALID0 ? MEM_DOUT : '0;
    assign RDATA1  = RVALID1 ? MEM_DOUT : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a MAX_WAIT=4 instance on a RAM stub plus a
// MAX_WAIT=0 instance, both checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int MAX_WAIT_A = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ0 = 1'b0, WE0 = 1'b0, REQ1 = 1'b0, WE1 = 1'b0;
    logic [15:0] ADDR0 = '0, ADDR1 = '0;
    logic [7:0]  WDATA0 = '0, WDATA1 = '0;

    logic        ACK0, ACK1, RVALID0, RVALID1, MEM_WE;
    logic [7:0]  RDATA0, RDATA1, MEM_DIN, MEM_DOUT;
    logic [15:0] MEM_ADDR;

    logic        ackB0, ackB1, rvalidB0, rvalidB1, memWeB;
    logic [7:0]  rdataB0, rdataB1, memDinB;
    logic [15:0] memAddrB;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state: byte contents, pending read return, DMA denial streak
    logic [7:0] shadow [int];
    int         dmaDenied;
    int         pendOwner;
    logic [7:0] pendData;
    int         pendOwnerB;
    int         lastGnt;
    logic       obsAck1, obsAckB1;

    logic        p0, p1, pw0, pw1;
    logic [15:0] pa0, pa1;
    logic [7:0]  pd0, pd1;

    mem_arbiter #(.MAX_WAIT(MAX_WAIT_A)) dutA (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0),
        .ACK0(ACK0), .RVALID0(RVALID0), .RDATA0(RDATA0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1),
        .ACK1(ACK1), .RVALID1(RVALID1), .RDATA1(RDATA1),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
    );

    mem_arbiter #(.MAX_WAIT(0)) dutB (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0),
        .ACK0(ackB0), .RVALID0(rvalidB0), .RDATA0(rdataB0),
        .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1),
        .ACK1(ackB1), .RVALID1(rvalidB1), .RDATA1(rdataB1),
        .MEM_WE(memWeB), .MEM_ADDR(memAddrB), .MEM_DIN(memDinB), .MEM_DOUT(8'h00)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] bootByte(input logic [15:0] a);
        case (a)
            16'h0000: return 8'hA2;
            16'h0037: return 8'hDD;
            16'h0107: return 8'hAA;
            16'h0110: return 8'hBB;
            default:  return a[7:0] ^ a[15:8] ^ 8'h3C;
        endcase
    endfunction

    // Synchronous RAM stub holding the boot image until a location is written
    logic [7:0] ramData [0:65535];
    bit         ramWritten [0:65535];
    always @(posedge CLK) begin
        if (MEM_WE) begin
            ramData[MEM_ADDR]    <= MEM_DIN;
            ramWritten[MEM_ADDR] <= 1'b1;
        end
        MEM_DOUT <= ramWritten[MEM_ADDR] ? ramData[MEM_ADDR] : bootByte(MEM_ADDR);
    end

    function automatic logic [7:0] modelRead(input logic [15:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : bootByte(a);
    endfunction

    task automatic resetModel();
        dmaDenied  = 0;
        pendOwner  = -1;
        pendOwnerB = -1;
        pendData   = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d observed=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".ack0"},    16'(ACK0),     16'h0);
        checkOutput({tag, ".ack1"},    16'(ACK1),     16'h0);
        checkOutput({tag, ".memWe"},   16'(MEM_WE),   16'h0);
        checkOutput({tag, ".memAddr"}, MEM_ADDR,      16'h0);
        checkOutput({tag, ".memDin"},  16'(MEM_DIN),  16'h0);
        checkOutput({tag, ".rvalid0"}, 16'(RVALID0),  16'h0);
        checkOutput({tag, ".rvalid1"}, 16'(RVALID1),  16'h0);
        checkOutput({tag, ".rdata0"},  16'(RDATA0),   16'h0);
        checkOutput({tag, ".rdata1"},  16'(RDATA1),   16'h0);
    endtask

    // Drive one cycle of requests, check every output against the model, then clock
    task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0, input logic [7:0] d0,
                                 input logic r1, input logic w1, input logic [15:0] a1, input logic [7:0] d1);
        int          g, gB;
        logic        eWe;
        logic [15:0] eAddr, eAddrB;
        logic [7:0]  eDin;
        REQ0 = r0; WE0 = w0; ADDR0 = a0; WDATA0 = d0;
        REQ1 = r1; WE1 = w1; ADDR1 = a1; WDATA1 = d1;
        #3;
        if (r0 && r1)  g = (MAX_WAIT_A != 0 && dmaDenied >= MAX_WAIT_A) ? 1 : 0;
        else if (r0)   g = 0;
        else if (r1)   g = 1;
        else           g = -1;
        gB = r0 ? 0 : (r1 ? 1 : -1);
        eWe = 1'b0; eAddr = '0; eDin = '0;
        if (g == 0) begin eWe = w0; eAddr = a0; eDin = d0; end
        if (g == 1) begin eWe = w1; eAddr = a1; eDin = d1; end
        eAddrB = (gB == 0) ? a0 : ((gB == 1) ? a1 : 16'h0000);

        checkOutput("A.ack0",    16'(ACK0),    16'(g == 0));
        checkOutput("A.ack1",    16'(ACK1),    16'(g == 1));
        checkOutput("A.memWe",   16'(MEM_WE),  16'(eWe));
        checkOutput("A.memAddr", MEM_ADDR,     eAddr);
        checkOutput("A.memDin",  16'(MEM_DIN), 16'(eDin));
        checkOutput("A.rvalid0", 16'(RVALID0), 16'(pendOwner == 0));
        checkOutput("A.rvalid1", 16'(RVALID1), 16'(pendOwner == 1));
        checkOutput("A.rdata0",  16'(RDATA0),  (pendOwner == 0) ? 16'(pendData) : 16'h0);
        checkOutput("A.rdata1",  16'(RDATA1),  (pendOwner == 1) ? 16'(pendData) : 16'h0);
        checkOutput("B.ack0",    16'(ackB0),   16'(gB == 0));
        checkOutput("B.ack1",    16'(ackB1),   16'(gB == 1));
        checkOutput("B.memAddr", memAddrB,     eAddrB);
        checkOutput("B.rvalid",  {14'h0, rvalidB1, rvalidB0},
                    {14'h0, pendOwnerB == 1, pendOwnerB == 0});
        obsAck1  = ACK1;
        obsAckB1 = ackB1;

        pendOwner = -1;
        if (g >= 0) begin
            if (!eWe) begin
                pendOwner = g;
                pendData  = modelRead(eAddr);
            end else begin
                shadow[int'(eAddr)] = eDin;
            end
        end
        dmaDenied  = (r1 && g != 1) ? dmaDenied + 1 : 0;
        pendOwnerB = (gB == 0 && !w0) ? 0 : ((gB == 1 && !w1) ? 1 : -1);
        lastGnt    = g;
        @(posedge CLK);
        #1;
        cycle++;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    initial begin
        resetModel();
        REQ0 = 1'b1; ADDR0 = 16'h0037;
        repeat (2) @(posedge CLK);
        #1;
        checkAllZero("reset");
        REQ0 = 1'b0; ADDR0 = '0;
        RESET = 1'b0;
        idleCycle();

        // Read accepted in the cycle reset asserts must never return data
        REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 16'h0037;
        #3;
        checkOutput("t1.ackBeforeReset", 16'(ACK0), 16'h1);
        RESET = 1'b1;
        #1;
        checkAllZero("t1.assert");
        @(posedge CLK);
        #1;
        checkAllZero("t1.held");
        REQ0 = 1'b0; ADDR0 = '0;
        RESET = 1'b0;
        resetModel();
        idleCycle();
        checkOutput("t1.noRvalidAfter", 16'(RVALID0), 16'h0);
        idleCycle();

        applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("t2.rdata0_0000", {7'h0, RVALID0, RDATA0}, 16'h01A2);
        applyStimulus(1'b1, 1'b0, 16'h0037, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("t2.rdata0_0037", {7'h0, RVALID0, RDATA0}, 16'h01DD);
        idleCycle();

        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b1, 16'h0200, 8'h5A);
        checkOutput("t3.writeNoRvalid", 16'(RVALID1), 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0200, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
        checkOutput("t3.crossRead", 16'(RDATA0), 16'h005A);
        idleCycle();

        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0107, 8'h0, 1'b1, 1'b0, 16'h0110, 8'h0);
            checkOutput("t4.ack1Pattern", 16'(obsAck1), 16'((i % 5) == 4));
        end
        idleCycle();

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0107, 8'h0, 1'b1, 1'b0, 16'h0110, 8'h0);
            checkOutput("t5.noAck1", 16'(obsAckB1), 16'h0);
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0110, 8'h0);
        checkOutput("t5.ack1AfterDrop", 16'(obsAckB1), 16'h1);

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                applyStimulus(1'b1, 1'b0, 16'h0107, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
                checkOutput("t6.rdata0", {7'h0, RVALID0, RDATA0}, 16'h01AA);
            end else begin
                applyStimulus(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 1'b0, 16'h0110, 8'h0);
                checkOutput("t6.rdata1", {7'h0, RVALID1, RDATA1}, 16'h01BB);
            end
        end
        idleCycle();

        // Random traffic on a small address window so reads and writes collide
        p0 = 1'b0; p1 = 1'b0;
        pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int i = 0; i < 300; i++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0  = 1'b1;
                pw0 = 1'($urandom_range(0, 1));
                pa0 = 16'h0200 + 16'($urandom_range(0, 7));
                pd0 = 8'($urandom);
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1  = 1'b1;
                pw1 = 1'($urandom_range(0, 1));
                pa1 = 16'h0200 + 16'($urandom_range(0, 7));
                pd1 = 8'($urandom);
            end
            applyStimulus(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1);
            if (lastGnt == 0) p0 = 1'b0;
            if (lastGnt == 1) p1 = 1'b0;
        end
        idleCycle();
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
